// File: rtl/fc_stream_engine.sv
// Streaming int8 fully-connected layer: loads features, biases and weights over AXIS,
// emits saturated int8 outputs and the argmax. Optional ReLU via FC_STREAM_RELU_EN.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_F | storing N/L feature beats
// LOAD_B | storing M bias beats
// LOAD_W | accumulating M*N/L weight beats, one output per row
// FLUSH  | last row result lands in the output buffer
// SEND   | emitting ceil(M/L) result beats
// DONE   | one-cycle completion pulse
module fc_stream_engine #(
   parameter int TDATA_W = 32,
   parameter int IN_MAX  = 1024,
   parameter int OUT_MAX = 64,
   parameter int SHIFT   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [15:0]          in_size,
   input  logic [15:0]          out_size,
   output logic                 busy,
   output logic                 done,
   output logic [15:0]          max_index,
   output logic [31:0]          cycle_cnt,
   output logic                 s_axis_tready,
   input  logic [TDATA_W-1:0]   s_axis_tdata,
   input  logic                 s_axis_tlast,
   input  logic                 s_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic [TDATA_W-1:0]   m_axis_tdata,
   output logic [TDATA_W/8-1:0] m_axis_tkeep,
   output logic                 m_axis_tlast,
   output logic                 m_axis_tvalid
);

   localparam int L       = TDATA_W / 8;
   localparam int F_DEPTH = IN_MAX / L;
   localparam int FA_W    = (F_DEPTH > 1) ? $clog2(F_DEPTH) : 1;
   localparam int OA_W    = (OUT_MAX > 1) ? $clog2(OUT_MAX) : 1;

   typedef enum logic [2:0] {IDLE, LOAD_F, LOAD_B, LOAD_W, FLUSH, SEND, DONE} state_t;
   state_t state, state_nxt;

   logic [TDATA_W-1:0] feat_mem [F_DEPTH];
   logic signed [31:0] bias_mem [OUT_MAX];
   logic signed [7:0]  out_mem  [OUT_MAX];

   logic [15:0]        n_beats, m_size, col, row, send_idx;
   logic [15:0]        n_clamp, m_clamp, send_beats, oidx;
   logic signed [31:0] acc, dot, acc_sum, row_total, shifted;
   logic signed [7:0]  fa, wa, sat_val, res_val, max_val;
   logic signed [15:0] prod;
   logic [TDATA_W-1:0] feat_beat;
   logic [15:0]        res_row;
   logic               res_vld, s_hs, m_hs, last_col, last_row;
   logic               unused_tlast;

   assign unused_tlast = s_axis_tlast;
   assign s_hs       = s_axis_tvalid & s_axis_tready;
   assign m_hs       = m_axis_tvalid & m_axis_tready;
   assign last_col   = (col == n_beats - 16'd1);
   assign last_row   = (row == m_size - 16'd1);
   assign send_beats = (m_size + 16'(L - 1)) / 16'(L);

   // Non-multiples of L round down; anything that would give zero beats becomes one beat.
   always_comb begin
      n_clamp = in_size / 16'(L);
      if (in_size > 16'(IN_MAX))
         n_clamp = 16'(F_DEPTH);
      else if (in_size < 16'(L))
         n_clamp = 16'd1;
      m_clamp = out_size;
      if (out_size == 16'd0)
         m_clamp = 16'd1;
      else if (out_size > 16'(OUT_MAX))
         m_clamp = 16'(OUT_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      busy          = 1'b1;
      done          = 1'b0;
      s_axis_tready = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = LOAD_F;
         end
         LOAD_F: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && last_col) state_nxt = LOAD_B;
         end
         LOAD_B: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && last_row) state_nxt = LOAD_W;
         end
         LOAD_W: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && last_col && last_row) state_nxt = FLUSH;
         end
         FLUSH: state_nxt = SEND;
         SEND: begin
            if (m_axis_tready && (send_idx == send_beats - 16'd1)) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // One weight beat against the matching feature beat.
   always_comb begin
      feat_beat = feat_mem[col[FA_W-1:0]];
      dot       = '0;
      fa        = '0;
      wa        = '0;
      prod      = '0;
      for (int i = 0; i < L; i++) begin
         fa   = feat_beat[8*i +: 8];
         wa   = s_axis_tdata[8*i +: 8];
         prod = fa * wa;
         dot  = dot + 32'(prod);
      end
      acc_sum   = acc + dot;
      row_total = acc_sum + bias_mem[row[OA_W-1:0]];
      shifted   = row_total >>> SHIFT;
`ifdef FC_STREAM_RELU_EN
      if (shifted < 32'sd0) shifted = '0;
`else
`endif
      if (shifted > 32'sd127)
         sat_val = 8'sd127;
      else if (shifted < -32'sd128)
         sat_val = -8'sd128;
      else
         sat_val = shifted[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n_beats   <= 16'd1;
         m_size    <= 16'd1;
         col       <= '0;
         row       <= '0;
         send_idx  <= '0;
         acc       <= '0;
         res_vld   <= 1'b0;
         res_val   <= '0;
         res_row   <= '0;
         max_val   <= '0;
         max_index <= '0;
         cycle_cnt <= '0;
      end else begin
         res_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  n_beats   <= n_clamp;
                  m_size    <= m_clamp;
                  col       <= '0;
                  row       <= '0;
                  send_idx  <= '0;
                  acc       <= '0;
                  max_val   <= '0;
                  max_index <= '0;
                  cycle_cnt <= '0;
               end
            end
            LOAD_F: if (s_hs) col <= last_col ? 16'd0 : col + 16'd1;
            LOAD_B: if (s_hs) row <= last_row ? 16'd0 : row + 16'd1;
            LOAD_W: begin
               if (s_hs) begin
                  if (last_col) begin
                     col     <= '0;
                     acc     <= '0;
                     res_vld <= 1'b1;
                     res_val <= sat_val;
                     res_row <= row;
                     row     <= row + 16'd1;
                  end else begin
                     col <= col + 16'd1;
                     acc <= acc_sum;
                  end
               end
            end
            SEND: if (m_hs) send_idx <= send_idx + 16'd1;
            default: ;
         endcase
         // Counts every busy cycle before DONE, so the value seen with done is final.
         if (state != IDLE && state != DONE)
            cycle_cnt <= cycle_cnt + 32'd1;
         if (res_vld && (res_row == 16'd0 || res_val > max_val)) begin
            max_val   <= res_val;
            max_index <= res_row;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == LOAD_F && s_hs) feat_mem[col[FA_W-1:0]] <= s_axis_tdata;
      if (state == LOAD_B && s_hs) bias_mem[row[OA_W-1:0]] <= s_axis_tdata[31:0];
      if (res_vld)                 out_mem[res_row[OA_W-1:0]] <= res_val;
   end

   // Result beat is read straight from the buffer; it cannot change while SEND stalls.
   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      oidx          = '0;
      if (state == SEND) begin
         m_axis_tvalid = 1'b1;
         m_axis_tlast  = (send_idx == send_beats - 16'd1);
         for (int i = 0; i < L; i++) begin
            oidx = send_idx * 16'(L) + 16'(i);
            if (oidx < m_size) begin
               m_axis_tdata[8*i +: 8] = out_mem[oidx[OA_W-1:0]];
               m_axis_tkeep[i]        = 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fc_stream_engine.sv
// Bench for fc_stream_engine: directed and random layers against an arithmetic reference model.
module tb_fc_stream_engine;
   localparam int L = 4, IN_MAX = 1024, OUT_MAX = 64, SHIFT = 8, TW = 32;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [15:0]   in_size, out_size;
   logic          busy, done;
   logic [15:0]   max_index;
   logic [31:0]   cycle_cnt;
   logic          s_axis_tready, s_axis_tlast, s_axis_tvalid;
   logic [TW-1:0] s_axis_tdata;
   logic          m_axis_tready, m_axis_tlast, m_axis_tvalid;
   logic [TW-1:0] m_axis_tdata;
   logic [L-1:0]  m_axis_tkeep;

   fc_stream_engine #(.TDATA_W(TW), .IN_MAX(IN_MAX), .OUT_MAX(OUT_MAX), .SHIFT(SHIFT)) dut (
      .clk(clk), .rst(rst), .start(start), .in_size(in_size), .out_size(out_size),
      .busy(busy), .done(done), .max_index(max_index), .cycle_cnt(cycle_cnt),
      .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
      .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid)
   );

   always #5 clk = ~clk;

   int unsigned edges = 0;
   always @(posedge clk) edges++;

   int vectors = 0, miscompares = 0;

   int feat [IN_MAX];
   int wt   [IN_MAX*OUT_MAX];
   int bias [OUT_MAX];
   int exp_out [OUT_MAX];
   int exp_max;
   logic [31:0]  stream [$];
   logic [31:0]  rx_data [$];
   logic [L-1:0] rx_keep [$];
   logic         rx_last [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic int sat8(input int v);
      int r = v;
`ifdef FC_STREAM_RELU_EN
      if (r < 0) r = 0;
`endif
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      return r;
   endfunction

   task automatic model(input int n, input int m);
      for (int r = 0; r < m; r++) begin
         int acc = 0;
         for (int i = 0; i < n; i++) acc += feat[i] * wt[r*n + i];
         acc = acc + bias[r];
         exp_out[r] = sat8(acc >>> SHIFT);
      end
      exp_max = 0;
      for (int r = 1; r < m; r++)
         if (exp_out[r] > exp_out[exp_max]) exp_max = r;
   endtask

   task automatic build(input int n, input int m);
      logic [31:0] beat;
      stream.delete();
      for (int b = 0; b < n/L; b++) begin
         for (int k = 0; k < L; k++) beat[8*k +: 8] = 8'(feat[b*L + k]);
         stream.push_back(beat);
      end
      for (int r = 0; r < m; r++) stream.push_back(32'(bias[r]));
      for (int r = 0; r < m; r++)
         for (int b = 0; b < n/L; b++) begin
            for (int k = 0; k < L; k++) beat[8*k +: 8] = 8'(wt[r*n + b*L + k]);
            stream.push_back(beat);
         end
   endtask

   task automatic fill_random(input int n, input int m);
      for (int i = 0; i < n; i++) feat[i] = int'($urandom_range(255)) - 128;
      for (int i = 0; i < n*m; i++) wt[i] = int'($urandom_range(255)) - 128;
      for (int r = 0; r < m; r++) bias[r] = int'($urandom_range(40000)) - 20000;
   endtask

   task automatic drive(input int count);
      int idx = 0, budget = 0;
      while (idx < count && budget < 60000) begin
         @(negedge clk);
         budget++;
         s_axis_tvalid = ($urandom_range(3) != 0);
         s_axis_tdata  = s_axis_tvalid ? stream[idx] : $urandom;
         s_axis_tlast  = 1'($urandom_range(1));
         if (s_axis_tvalid && s_axis_tready) idx++;
      end
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      chk("drv_beats", 64'(idx), 64'(count));
   endtask

   task automatic receive(input int nbeats, input bit poke);
      int got = 0, budget = 0;
      bit stall = 0, poked = 0;
      logic [31:0] pd = '0;
      rx_data.delete(); rx_keep.delete(); rx_last.delete();
      while (got < nbeats && budget < 60000) begin
         @(negedge clk);
         budget++;
         if (poked) start = 1'b0;
         if (stall) begin
            chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
            chk("hold_data", 64'(m_axis_tdata), 64'(pd));
         end
         if (poke && !poked && m_axis_tvalid) begin
            start = 1'b1; in_size = 16'd4; out_size = 16'd1; poked = 1;
         end
         m_axis_tready = 1'($urandom_range(1));
         if (m_axis_tvalid && m_axis_tready) begin
            rx_data.push_back(m_axis_tdata);
            rx_keep.push_back(m_axis_tkeep);
            rx_last.push_back(m_axis_tlast);
            got++;
         end
         stall = m_axis_tvalid && !m_axis_tready;
         pd    = m_axis_tdata;
      end
      chk("rx_beats", 64'(got), 64'(nbeats));
   endtask

   task automatic run_layer(input int raw_in, input int raw_out, input bit poke, input bit rnd);
      int n, m, nb;
      int unsigned e0;
      logic [31:0] exp_cc, d;
      logic [L-1:0] kp;
      n  = (raw_in == 0) ? L : (raw_in > IN_MAX) ? IN_MAX : raw_in;
      m  = (raw_out == 0) ? 1 : (raw_out > OUT_MAX) ? OUT_MAX : raw_out;
      nb = (m + L - 1) / L;
      if (rnd) fill_random(n, m);
      model(n, m);
      build(n, m);
      @(negedge clk);
      start = 1'b1; in_size = 16'(raw_in); out_size = 16'(raw_out);
      e0 = edges;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
      fork
         drive(stream.size());
         receive(nb, poke);
      join
      start = 1'b0;
      @(negedge clk);
      exp_cc = 32'(edges - (e0 + 1));
      chk("done_pulse", 64'(done), 64'd1);
      chk("cycle_cnt", 64'(cycle_cnt), 64'(exp_cc));
      chk("max_index", 64'(max_index), 64'(exp_max));
      for (int b = 0; b < nb && b < rx_data.size(); b++) begin
         d = '0; kp = '0;
         for (int k = 0; k < L; k++)
            if (b*L + k < m) begin
               d[8*k +: 8] = 8'(exp_out[b*L + k]);
               kp[k] = 1'b1;
            end
         chk("beat_data", 64'(rx_data[b]), 64'(d));
         chk("beat_keep", 64'(rx_keep[b]), 64'(kp));
         chk("beat_last", 64'(rx_last[b]), 64'(b == nb - 1));
      end
      @(negedge clk);
      chk("done_once", 64'(done), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("cycle_frozen", 64'(cycle_cnt), 64'(exp_cc));
      chk("max_held", 64'(max_index), 64'(exp_max));
   endtask

   initial begin
      logic [31:0] w0;
      rst = 1'b1; start = 1'b0; in_size = '0; out_size = '0;
      s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
      chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
      chk("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
      chk("rst_m_tkeep", 64'(m_axis_tkeep), 64'd0);
      chk("rst_max_index", 64'(max_index), 64'd0);
      chk("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
      rst = 1'b0;

      // Smallest layer: 1+2+3+4 = 10, plus 256, >>> 8 gives 1.
      for (int i = 0; i < 4; i++) begin feat[i] = i + 1; wt[i] = 1; end
      bias[0] = 256;
      run_layer(4, 1, 0, 0);
      w0 = rx_data.size() > 0 ? rx_data[0] : 32'hffffffff;
      chk("basic_byte0", 64'(w0[7:0]), 64'd1);

      run_layer(8, 6, 0, 1);

      // 127, saturated 127, 5 and a deeply negative row.
      for (int i = 0; i < 4; i++) feat[i] = 1;
      for (int i = 0; i < 16; i++) wt[i] = 0;
      bias[0] = 32512; bias[1] = 200000; bias[2] = 1283; bias[3] = -10240000;
      run_layer(4, 4, 0, 0);
      w0 = rx_data.size() > 0 ? rx_data[0] : 32'h0;
`ifdef FC_STREAM_RELU_EN
      chk("neg_row", 64'(w0[31:24]), 64'h00);
`else
      chk("neg_row", 64'(w0[31:24]), 64'h80);
`endif
      chk("tie_index", 64'(max_index), 64'd0);

      // Abandon a layer part-way through the weights.
      fill_random(8, 2);
      build(8, 2);
      @(negedge clk);
      start = 1'b1; in_size = 16'd8; out_size = 16'd2;
      @(negedge clk);
      start = 1'b0;
      drive(7);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_s_tready", 64'(s_axis_tready), 64'd0);
      chk("abort_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      run_layer(8, 2, 0, 1);

      run_layer(16, 10, 1, 1);
      run_layer(0, 0, 0, 1);
      run_layer(8, 100, 0, 1);
      run_layer(2000, 3, 0, 1);
      for (int t = 0; t < 3; t++)
         run_layer(L * int'($urandom_range(1, 12)), int'($urandom_range(1, 20)), 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fc_stream_engine.md
FC_STREAM_ENGINE -- requirements
Module: fc_stream_engine

Interface
REQ-001 Parameter TDATA_W, default 32: AXIS data width in bits; lanes L = TDATA_W/8 int8 elements per beat (legal values 32, 64).
REQ-002 Parameter IN_MAX, default 1024: maximum input feature count; must be a multiple of L.
REQ-003 Parameter OUT_MAX, default 64: maximum output neuron count.
REQ-004 Parameter SHIFT, default 8: arithmetic right shift applied to each accumulator before saturation.
REQ-005 Ports, one per line (name  direction  width  meaning):
clk  in  1  sole clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse that begins a layer.
in_size  in  16  feature count N (multiple of L, 1..IN_MAX); sampled on start.
out_size  in  16  neuron count M (1..OUT_MAX); sampled on start.
busy  out  1  high from accepted start until done.
done  out  1  one-cycle completion pulse.
max_index  out  16  index of the largest output neuron.
cycle_cnt  out  32  cycles from accepted start to done.
s_axis_tready/tdata/tlast/tvalid  in/out  1/TDATA_W/1/1  input stream (tready is the output).
m_axis_tready/tdata/tkeep/tlast/tvalid  in/out  1/TDATA_W/TDATA_W/8/1/1  result stream (tready is the input).

Function
REQ-006 The FSM SHALL have the states IDLE, LOAD_F, LOAD_B, LOAD_W, FLUSH, SEND and DONE.
REQ-007 The accepted start SHALL move the FSM IDLE->LOAD_F; start in any other state SHALL be ignored; busy SHALL be high in every state except IDLE.
REQ-008 s_axis_tready SHALL be 1 only in LOAD_F, LOAD_B and LOAD_W; a beat transfers only when tvalid and tready are both high.
REQ-009 LOAD_F SHALL store N/L feature beats, little-endian lanes (byte 0 = lowest index), then go to LOAD_B.
REQ-010 LOAD_B SHALL store M beats, each carrying a signed 32-bit bias in bits [31:0], then go to LOAD_W.
REQ-011 LOAD_W SHALL accept M*N/L weight beats, row-major; each beat SHALL add the L signed 8x8 products to a 32-bit wrapping accumulator.
REQ-012 On the last beat of each row, the accumulator plus bias SHALL be shifted arithmetically right by SHIFT, saturated to [-128,127] and stored in the output buffer one cycle later; the accumulator SHALL then clear.
REQ-013 The argmax SHALL update only on strict greater-than, so on ties the lowest index wins; max_index SHALL be valid when done pulses and held until the next accepted start.
REQ-014 After the last weight beat, FLUSH SHALL last exactly 1 cycle before entering SEND.
REQ-015 SEND SHALL emit ceil(M/L) beats; any lanes beyond M SHALL be zero with their tkeep bit 0; tlast SHALL be set on the final beat only.
REQ-016 m_axis_tvalid, once asserted, SHALL hold with tdata stable until m_axis_tready is high.
REQ-017 After the final m_axis handshake, the FSM SHALL enter DONE, pulse done for 1 cycle, then return to IDLE.
REQ-018 s_axis_tlast SHALL be ignored.
REQ-019 cycle_cnt SHALL clear on the accepted start, increment every busy cycle, and freeze when done pulses.
REQ-020 in_size or out_size of 0, or above the maximum, SHALL be clamped to the legal range: 0 becomes the minimum, and values above the maximum become IN_MAX (N, rounded down to a multiple of L) or OUT_MAX (M).

Reset
REQ-021 While rst is high, the FSM SHALL be in IDLE and busy, done, s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, max_index and cycle_cnt SHALL all be 0.
REQ-022 rst asserted mid-operation SHALL abandon the layer at the next edge; buffer contents SHALL be don't-care afterwards.

Configuration
REQ-023 Macro FC_STREAM_RELU_EN: when defined, negative values after the shift SHALL become 0 before saturation and argmax; when undefined, no ReLU SHALL be applied.

Verification
REQ-024 L=4, N=4, M=1, features 1,2,3,4, weights 1,1,1,1, bias 256, SHIFT=8 -> 1 output beat, byte0=1, tkeep=0001, tlast=1, max_index=0, done one cycle after the handshake.
REQ-025 M=6, N=8, random data, m_axis_tready toggling 50% -> 2 output beats matching the reference model, second beat tkeep=0011, tvalid/tdata stable while stalled.
REQ-026 Outputs forced to 127,127,5 (saturation tie) -> max_index=0; a row summing to -40000 (after shift) -> 0x80 without FC_STREAM_RELU_EN, 0x00 with it.
REQ-027 rst pulsed for 1 cycle during LOAD_W -> busy=0, s_axis_tready=0 next cycle; a following full layer gives correct results.
REQ-028 start pulsed during SEND -> ignored; cycle_cnt equals the cycle count from the first start to done, including stall cycles.
